aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Iterative AES-128 key expansion engine feeding the AddRoundKey stage of the cipher datapath. It accepts a 128-bit cipher key over a valid/ready handshake and emits the eleven round keys one at a time over a second valid/ready handshake, one key per cycle when the consumer is ready. It is the producer side of the round-key interface that AddRoundKey consumes. An optional build adds reverse-order output (round 10 down to 0) for the inverse cipher.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- key_in  input  128  cipher key; byte 0 in [127:120], word w0 = [127:96]
- key_valid  input  1  key_in valid
- key_ready  output  1  high only in IDLE
- mode_dec  input  1  present only with AES_INV_KEY_ORDER_EN; 1 = emit keys in reverse order; sampled on key accept
- rk_out  output  128  current round key, same byte/word order as key_in
- rk_round  output  4  round index of rk_out (0..10)
- rk_valid  output  1  rk_out/rk_round valid
- rk_ready  input  1  consumer accepts the current key
- busy  output  1  state != IDLE

## Operation
- States: IDLE, EXPAND (only with macro), EMIT.
- IDLE: key_ready=1. On key_valid&&key_ready: rk_out<=key_in, rk_round<=0. Goes to EMIT, or to EXPAND if mode_dec=1.
- EMIT forward: rk_valid=1. On rk_valid&&rk_ready with rk_round<10: rk_out<=next(rk_out), rk_round+1. At rk_round=10, handshake returns to IDLE and drops rk_valid.
- next(w0..w3) for target round r: n0=w0^SubWord(RotWord(w3))^{Rcon[r],24'h0}; n1=w1^n0; n2=w2^n1; n3=w3^n2.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. RotWord [a0,a1,a2,a3] -> [a1,a2,a3,a0]. SubWord applies the AES S-box per byte.
- EXPAND: steps next() once per cycle, rk_valid=0, until rk_round=10, then goes to EMIT reverse.
- EMIT reverse: on handshake with rk_round>0: rk_out<=prev(rk_out), rk_round-1. At rk_round=0, handshake returns to IDLE.
- prev() from round r: p3=w3^w2; p2=w2^w1; p1=w1^w0; p0=w0^SubWord(RotWord(p3))^{Rcon[r],24'h0}.
- rk_out and rk_round are held stable while rk_valid=1 and rk_ready=0.
- No abort input. The original key is not retained after the sequence completes.

## Timing
- Reset (asserted): state=IDLE, rk_out=0, rk_round=0, rk_valid=0, busy=0, key_ready=1.
- Forward: round 0 is valid the cycle after accept. With rk_ready held high, rounds 0..10 appear on 11 consecutive cycles.
- Reverse: EXPAND occupies 10 cycles. rk_valid rises 11 cycles after the accept edge with rk_round=10. Rounds 10..0 then follow on consecutive cycles.
- key_ready drops the cycle after accept and returns the cycle after the final key handshake. A new key therefore has a minimum 1-cycle bubble; the final handshake and the next accept never share a cycle.
- rk_ready=0 stalls indefinitely with no state change. rk_ready is ignored while rk_valid=0.
- rst_n low mid-sequence: immediate return to reset values; the partial sequence is discarded.

## Configuration
- AES_INV_KEY_ORDER_EN defined: mode_dec port, EXPAND state, and prev() datapath are present.
- AES_INV_KEY_ORDER_EN undefined: no mode_dec port, forward order only, and EXPAND is unreachable or removed.
- Reset values and forward behaviour are identical in both builds.

## Structure
- Shared package aes_pkg holds:
  - the state enum type;
  - the RCON constant array indexed 1..10;
  - the NR=10 constant;
  - the 128-bit key and 32-bit word typedefs.
- Sub-module aes_sbox: combinational 8-bit S-box. Four instances form SubWord, shared by next() and prev() through a mux on the input word (w3 vs p3).

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round 0 equals the key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - exactly 11 consecutive valid cycles.
- Same key with rk_ready toggling 1,0,0,1 pseudo-randomly: the same 11 keys, in order, with no duplicates or skips, and rk_out stable while stalled.
- Macro on, same key with mode_dec=1:
  - rk_valid rises 11 cycles after accept with round 10 = d014f9a8…;
  - sequence ends with round 0 = 2b7e1516…;
  - rk_round counts 10..0.
- key_valid held high through the whole sequence: exactly one accept, and key_ready returns one cycle after the final handshake.
- rst_n pulsed low during round 5 with rk_ready=0: rk_valid=0 and rk_out=0 immediately, key_ready=1 after release, and the next key starts at round 0.
- All-zero key: round 1 = 62636363626363636263636362636363.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared state type, round constants and word/key types for the AES-128 key schedule.
package aes_pkg;
    typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;
    typedef logic [127:0] key_t;
    typedef logic [31:0] word_t;
    localparam int NR = 10;
    localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    function automatic logic [7:0] rcon(input logic [3:0] r);
        return (r >= 4'd1 && r <= 4'd10) ? RCON[r] : 8'h00;
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box, one byte in, one byte out.
module aes_sbox import aes_pkg::*; (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    assign y = SBOX[a];
endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128 key expansion emitting round keys 0..10 over valid/ready.
// Define AES_INV_KEY_ORDER_EN to add the mode_dec port and reverse (10..0) emission.
module aes_key_schedule import aes_pkg::*; (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
`ifdef AES_INV_KEY_ORDER_EN
    input  logic         mode_dec,
`endif
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);
    state_t state, state_next;
    logic   dec, start_dec, rev, accept, step, done;
    word_t  w0, w1, w2, w3, p1, p2, p3, sub_in, rot, sub, t0;
    logic [7:0] rc;
    key_t   next_key, prev_key;
`ifdef AES_INV_KEY_ORDER_EN
    assign start_dec = mode_dec;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dec <= 1'b0;
        else if (accept) dec <= mode_dec;
`else
    assign start_dec = 1'b0;
    assign dec = 1'b0;
`endif
    assign {w0, w1, w2, w3} = rk_out;
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    // EXPAND runs forward even in decrypt mode; only reverse emission walks back
    assign rev = dec && state == EMIT;
    assign sub_in = rev ? p3 : w3;
    assign rot = {sub_in[23:0], sub_in[31:24]};
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_sbox
            aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
        end
    endgenerate
    assign rc = rcon(rev ? rk_round : rk_round + 4'd1);
    assign t0 = w0 ^ sub ^ {rc, 24'h0};
    assign next_key = {t0, w1 ^ t0, w2 ^ w1 ^ t0, w3 ^ w2 ^ w1 ^ t0};
    assign prev_key = {t0, p1, p2, p3};
    assign accept = state == IDLE && key_valid;
    assign step = state == EXPAND || (state == EMIT && rk_ready);
    assign done = state == EMIT && rk_ready && rk_round == (dec ? 4'd0 : 4'(NR));
    assign key_ready = state == IDLE;
    assign rk_valid = state == EMIT;
    assign busy = state != IDLE;
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (key_valid) state_next = start_dec ? EXPAND : EMIT;
            EXPAND:  if (rk_round == 4'(NR - 1)) state_next = EMIT;
            EMIT:    if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    // the key material is wiped when the sequence completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_out   <= '0;
            rk_round <= '0;
        end else if (accept) begin
            rk_out   <= key_in;
            rk_round <= '0;
        end else if (done) begin
            rk_out   <= '0;
            rk_round <= '0;
        end else if (step) begin
            rk_out   <= rev ? prev_key : next_key;
            rk_round <= rev ? rk_round - 4'd1 : rk_round + 4'd1;
        end
    end
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: randomized scoreboard bench checking round keys against a FIPS-197 model.
module tb_aes_key_schedule;
    logic         clk = 0, rst_n = 0, key_valid = 0, mode_dec = 0, rk_ready = 0, man_rdy = 1;
    logic [127:0] key_in = '0, rk_out;
    logic [3:0]   rk_round;
    logic         key_ready, rk_valid, busy;
    typedef struct {logic [127:0] k; logic [3:0] r;} exp_t;
    exp_t exp_q[$];
    int n_cmp = 0, n_bad = 0, rdy_mode = 0;
    logic [7:0] sb [256];
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    aes_key_schedule dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
`ifdef AES_INV_KEY_ORDER_EN
        .mode_dec(mode_dec),
`endif
        .rk_out(rk_out), .rk_round(rk_round), .rk_valid(rk_valid), .rk_ready(rk_ready), .busy(busy)
    );

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key, output logic [127:0] rk [11]);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic push_seq(input logic [127:0] key, input logic dec);
        logic [127:0] rk [11];
        int r;
        expand(key, rk);
        if (key == FIPS_KEY) begin
            rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
            rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        end
        if (key == '0) rk[1] = 128'h62636363626363636263636362636363;
        for (int j = 0; j < 11; j++) begin
            r = dec ? 10 - j : j;
            exp_q.push_back('{rk[r], 4'(r)});
        end
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (key_ready) break;
        end
        check("idle_wait", 128'(key_ready), 128'd1);
    endtask

    task automatic accept_key(input logic [127:0] key, input logic dec);
        wait_idle();
        @(posedge clk); #1;
        key_in = key; mode_dec = dec; key_valid = 1;
        @(posedge clk); #1;
        key_valid = 0;
        check("ready_drop", 128'(key_ready), 128'd0);
    endtask

    task automatic run_key(input logic [127:0] key, input logic dec, input logic burst);
        int lat = 0, n = 1;
        push_seq(key, dec);
        accept_key(key, dec);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (rk_valid) break;
        end
        check("first_valid_latency", 128'(lat), dec ? 128'd11 : 128'd1);
        if (burst) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!rk_valid) break;
                n++;
            end
            check("burst_len", 128'(n), 128'd11);
            check("kr_after_burst", 128'(key_ready), 128'd1);
        end
        for (int i = 0; i < 1000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 128'(exp_q.size()), 128'd0);
    endtask

    always @(posedge clk) begin
        #1;
        rk_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : man_rdy;
    end

    // monitor: compare every presented key to the head of the queue, pop on handshake
    always @(negedge clk) begin
        if (rk_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_key: got round %0d %h expected none", rk_round, rk_out);
            end else begin
                check("rk_out", rk_out, exp_q[0].k);
                check("rk_round", 128'(rk_round), 128'(exp_q[0].r));
                if (rk_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] k;
        int n_acc, seen;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rk_valid", 128'(rk_valid), 128'd0);
        check("rst_rk_out", rk_out, 128'd0);
        check("rst_rk_round", 128'(rk_round), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_key_ready", 128'(key_ready), 128'd1);
        @(posedge clk); #1;
        rst_n = 1;
        rdy_mode = 0; run_key(FIPS_KEY, 0, 1);
        rdy_mode = 1; run_key(FIPS_KEY, 0, 0);
        rdy_mode = 0; run_key('0, 0, 1);
        rdy_mode = 1;
        repeat (4) run_key({$urandom, $urandom, $urandom, $urandom}, 0, 0);
`ifdef AES_INV_KEY_ORDER_EN
        rdy_mode = 0; run_key(FIPS_KEY, 1, 1);
        rdy_mode = 1;
        repeat (3) run_key({$urandom, $urandom, $urandom, $urandom}, 1, 0);
`endif
        // key_valid held through the whole sequence
        rdy_mode = 0;
        k = {$urandom, $urandom, $urandom, $urandom};
        push_seq(k, 0);
        wait_idle();
        @(posedge clk); #1;
        key_in = k; mode_dec = 0; key_valid = 1;
        n_acc = 0; seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rk_valid) seen = 1;
            else if (seen != 0) break;
            if (key_ready) n_acc++;
        end
        check("kr_return", 128'(key_ready), 128'd1);
        key_valid = 0;
        check("one_accept", 128'(n_acc), 128'd1);
        check("hold_drain", 128'(exp_q.size()), 128'd0);
        // reset while stalled on round 5
        man_rdy = 1; rdy_mode = 2;
        k = {$urandom, $urandom, $urandom, $urandom};
        push_seq(k, 0);
        accept_key(k, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rk_valid && rk_round == 4'd4) begin
                man_rdy = 0;
                break;
            end
        end
        repeat (4) @(negedge clk);
        check("stall_round", 128'(rk_round), 128'd5);
        #2 rst_n = 0;
        #1;
        check("mid_rst_rk_valid", 128'(rk_valid), 128'd0);
        check("mid_rst_rk_out", rk_out, 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        exp_q.delete();
        @(negedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("post_rst_key_ready", 128'(key_ready), 128'd1);
        rdy_mode = 0;
        run_key({$urandom, $urandom, $urandom, $urandom}, 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
